sprite_line_fetch: RTL and testbench

SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_line_buf.sv | 31 +++
 rtl/sprite_line_fetch.sv | 162 ++++++++++++++++
 tb/tb_sprite_line_fetch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line fetcher: geometry defaults,
// the transparent key colour, the fetch FSM encoding and a ROM index helper.
package sprite_pkg;

  localparam int          SPRITE_W  = 64;
  localparam int          SPRITE_H  = 64;
  localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Linear sprite ROM address of (row, col) for a row stride of 'stride' pixels.
  function automatic logic [12:0] rom_index(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned stride);
    return 13'(row * stride + col);
  endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// One sprite row of pixels: synchronous write from the ROM fetch side,
// combinational read from the display side.
module sprite_line_buf #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 24,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Capture one fetched pixel per write strobe.
  // NOTE: the storage array has no reset; its contents are only ever read
  // after a complete row has been written, so clearing it would buy nothing.
  // NOTE: clocked state is always assigned with <= so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sprite_line_fetch.sv
// Sprite line fetcher. During horizontal blanking it copies the sprite row
// that intersects the next display line from the sprite ROM into a line
// buffer, then overlays that row on the visible line with one cycle of
// latency, suppressing key-coloured (transparent) pixels.
module sprite_line_fetch #(
  parameter int          SPRITE_W  = sprite_pkg::SPRITE_W,
  parameter int          SPRITE_H  = sprite_pkg::SPRITE_H,
  parameter logic [23:0] KEY_COLOR = sprite_pkg::KEY_COLOR
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        line_start,
  input  logic [9:0]  next_y,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        sprite_en,
  input  logic [9:0]  DrawX,
  output logic [12:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [23:0] pixel_out,
  output logic        pixel_valid,
  output logic        busy
);

  import sprite_pkg::*;

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPRITE_W - 1);

  fetch_state_t     state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             row_hit_q, row_hit_d;
  logic [12:0]      rom_addr_q, rom_addr_d;
  logic [9:0]       sx_q;

  // Row of the sprite that lands on the next line; negative means above it.
  logic [10:0]      row_calc;
  logic             row_in_range;

  // Line-buffer write port.
  logic             buf_we;
  logic [COL_W-1:0] buf_waddr;

  // Display side: column offset into the sprite and the buffered pixel there.
  logic [10:0]      dx;
  pixel_t           buf_rdata;
  logic             pix_hit;

  assign row_calc     = {1'b0, next_y} - {1'b0, sprite_y};
  assign row_in_range = sprite_en && !row_calc[10] && (row_calc < 11'(SPRITE_H));

  assign dx = {1'b0, DrawX} - {1'b0, sx_q};

  // A new line_start masks the output too, so nothing from the previous row
  // leaks into the first busy cycle.
  assign pix_hit = row_hit_q && !line_start && !dx[10] &&
                   (dx < 11'(SPRITE_W)) && (buf_rdata != KEY_COLOR);

  assign busy     = (state_q != IDLE);
  assign rom_addr = rom_addr_q;

  // Next-state, address sequencing and line-buffer write control.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_hit_d  = row_hit_q;
    rom_addr_d = rom_addr_q;
    buf_we     = 1'b0;
    buf_waddr  = col_q - COL_W'(1);

    if (line_start) begin
      // A new line always wins, including over a fetch still in flight.
      row_hit_d = 1'b0;
      col_d     = '0;
      if (row_in_range) begin
        state_d    = FETCH;
        row_d      = row_calc[ROW_W-1:0];
        rom_addr_d = rom_index(32'(row_calc[ROW_W-1:0]), 0, SPRITE_W);
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // Hold the last address and buffer contents.
        end
        FETCH: begin
          // Data arriving now belongs to the address issued last cycle.
          buf_we = (col_q != '0);
          if (col_q == LAST_COL) begin
            state_d = DRAIN;
          end else begin
            col_d      = col_q + COL_W'(1);
            rom_addr_d = rom_index(32'(row_q), 32'(col_q) + 32'd1, SPRITE_W);
          end
        end
        DRAIN: begin
          // Last word of the row lands here; the row becomes displayable.
          buf_we    = 1'b1;
          buf_waddr = LAST_COL;
          row_hit_d = 1'b1;
          col_d     = '0;
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Fetch state registers and the latched horizontal sprite position.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      row_hit_q  <= 1'b0;
      rom_addr_q <= '0;
      sx_q       <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_hit_q  <= row_hit_d;
      rom_addr_q <= rom_addr_d;
      if (line_start) begin
        sx_q <= sprite_x;
      end
    end
  end

  // Register the overlay result one cycle after DrawX is presented.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_valid <= 1'b0;
      pixel_out   <= '0;
    end else begin
      pixel_valid <= pix_hit;
      pixel_out   <= pix_hit ? buf_rdata : '0;
    end
  end

  sprite_line_buf #(
    .DEPTH (SPRITE_W),
    .WIDTH (24)
  ) u_line_buf (
    .Clk     (Clk),
    .wr_en   (buf_we),
    .wr_addr (buf_waddr),
    .wr_data (rom_data),
    .rd_addr (dx[COL_W-1:0]),
    .rd_data (buf_rdata)
  );

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Self-checking bench for sprite_line_fetch: directed scenarios followed by
// randomized lines, compared against a behavioural model of the sprite row
// overlay built from ROM contents and plain arithmetic.
module tb_sprite_line_fetch;

  localparam int          W   = 64;
  localparam int          H   = 64;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  next_y = '0;
  logic [9:0]  sprite_x = '0;
  logic [9:0]  sprite_y = '0;
  logic        sprite_en = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [12:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic [23:0] pixel_out;
  logic        pixel_valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Sprite ROM image and the model's view of the displayed row.
  logic [23:0] rom_mem [0:8191];
  bit          m_hit = 1'b0;
  int          m_sx  = 0;
  logic [23:0] m_buf [0:W-1];

  sprite_line_fetch dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .line_start  (line_start),
    .next_y      (next_y),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .sprite_en   (sprite_en),
    .DrawX       (DrawX),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the ROM answers the address seen during the old cycle.
  task automatic tick();
    logic [12:0] a;
    a = rom_addr;
    @(posedge Clk);
    #1;
    rom_data = rom_mem[a];
  endtask

  // Expected {valid, colour} for a DrawX under the current model state.
  function automatic logic [24:0] exp_px(input int d);
    int dx;
    dx = d - m_sx;
    if (m_hit && dx >= 0 && dx < W && m_buf[dx] != KEY) return {1'b1, m_buf[dx]};
    return 25'd0;
  endfunction

  task automatic check_px(input int d);
    logic [24:0] e;
    DrawX = 10'(d);
    e = exp_px(int'(DrawX));
    tick();
    check($sformatf("pix_valid@%0d", DrawX), 32'(pixel_valid), 32'(e[24]));
    check($sformatf("pix_data@%0d", DrawX), 32'(pixel_out), 32'(e[23:0]));
  endtask

  // Pulse line_start; report whether the sprite row falls on the line.
  task automatic start_line(input bit en, input int sx, input int sy, input int ny,
                            output bit fetch, output int row);
    sprite_en  = en;
    sprite_x   = 10'(sx);
    sprite_y   = 10'(sy);
    next_y     = 10'(ny);
    row        = int'(next_y) - int'(sprite_y);
    fetch      = en && row >= 0 && row < H;
    m_sx       = int'(sprite_x);
    m_hit      = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Follow a full row fetch: address sequence, busy window, no output.
  task automatic run_fetch(input int row);
    DrawX = 10'(m_sx + 3);
    for (int i = 0; i <= W; i++) begin
      check($sformatf("busy_fetch[%0d]", i), 32'(busy), 32'd1);
      check($sformatf("pv_busy[%0d]", i), 32'(pixel_valid), 32'd0);
      if (i < W) check($sformatf("rom_addr[%0d]", i), 32'(rom_addr), 32'(row * W + i));
      tick();
    end
    check("busy_done", 32'(busy), 32'd0);
    for (int c = 0; c < W; c++) m_buf[c] = rom_mem[row * W + c];
    m_hit = 1'b1;
  endtask

  task automatic idle_check();
    for (int i = 0; i < 3; i++) begin
      check("busy_nofetch", 32'(busy), 32'd0);
      tick();
    end
  endtask

  task automatic do_line(input bit en, input int sx, input int sy, input int ny);
    bit fetch;
    int row;
    start_line(en, sx, sy, ny, fetch, row);
    if (fetch) run_fetch(row);
    else idle_check();
  endtask

  initial begin
    bit fetch;
    int row;
    int sx;
    int ny;

    for (int i = 0; i < 8192; i++) rom_mem[i] = 24'(i);

    // Reset state.
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pv", 32'(pixel_valid), 32'd0);
    check("rst_pix", 32'(pixel_out), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    Reset_n = 1'b1;
    tick();
    check_px(5);

    // Row 5 of a sprite at y=100: addresses 320..383, then overlay at x=200.
    do_line(1'b1, 200, 100, 105);
    check_px(210);
    check("req34_pix", 32'(pixel_out), 32'd330);
    check_px(199);
    check_px(200);
    check_px(263);
    check_px(264);

    // Rows just outside the sprite: no fetch, nothing drawn.
    do_line(1'b1, 200, 100, 99);
    for (int d = 0; d < 1024; d += 61) check_px(d);
    check_px(230);
    do_line(1'b1, 200, 100, 164);
    check_px(200);
    check_px(263);
    // Disabled sprite on an in-range row.
    do_line(1'b0, 200, 100, 120);
    check_px(210);

    // Transparent entry 5 with the sprite at x=0.
    rom_mem[5] = KEY;
    do_line(1'b1, 0, 0, 0);
    check_px(5);
    check_px(6);
    check_px(0);
    check_px(63);
    check_px(64);
    rom_mem[5] = 24'd5;

    // Right-hand boundary near the screen edge.
    do_line(1'b1, 600, 100, 100);
    check_px(599);
    check_px(600);
    check_px(663);
    check_px(664);

    // Last sprite row, and a sprite straddling the 10-bit column wrap.
    do_line(1'b1, 1000, 0, 63);
    check_px(1000);
    check_px(1023);
    check_px(0);
    check_px(5);

    // Abort at fetch cycle 30: restart on row 10 from address 640.
    start_line(1'b1, 200, 100, 105, fetch, row);
    for (int i = 0; i < 30; i++) begin
      check("abort_addr", 32'(rom_addr), 32'(320 + i));
      tick();
    end
    check("abort_busy_pre", 32'(busy), 32'd1);
    start_line(1'b1, 200, 100, 110, fetch, row);
    run_fetch(row);
    check_px(210);
    check("req38_pix", 32'(pixel_out), 32'd650);

    // Asynchronous reset while a pixel is being shown.
    check_px(205);
    check("pv_before_rst", 32'(pixel_valid), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("async_pv", 32'(pixel_valid), 32'd0);
    check("async_pix", 32'(pixel_out), 32'd0);
    m_hit = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();

    // Asynchronous reset at fetch cycle 10 discards the row.
    start_line(1'b1, 300, 50, 60, fetch, row);
    for (int i = 0; i < 10; i++) tick();
    check("busy_pre_rst", 32'(busy), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_pv", 32'(pixel_valid), 32'd0);
    check("rst_mid_addr", 32'(rom_addr), 32'd0);
    m_hit = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    for (int d = 298; d < 370; d += 7) check_px(d);
    do_line(1'b1, 300, 50, 60);
    for (int d = 298; d < 370; d += 7) check_px(d);

    // Randomized lines and ROM images.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4096; i++)
        rom_mem[i] = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
      sx = int'($urandom_range(0, 1023));
      row = int'($urandom_range(0, 1023));
      ny = row + int'($urandom_range(0, 80)) - 8;
      do_line($urandom_range(0, 3) != 0, sx, row, ny);
      for (int k = 0; k < 12; k++) check_px(sx + int'($urandom_range(0, 70)) - 3);
      for (int k = 0; k < 4; k++) check_px(int'($urandom_range(0, 1023)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
